// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg
// Shared constants and types for the SHA-256 front end and core:
//   - SHA-256 initial hash values H0..H7 and round constants K0..K63
//   - message loader defaults (maximum message bytes, block word count, pad byte)
//   - loader FSM state encoding
// ----------------------------------------------------------------------------
package sha256_pkg;

    // Initial hash values H0..H7
    localparam logic [31:0] SHA256_H [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Round constants K0..K63
    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Longest accepted message; must stay in 1..55 so the pad byte fits
    localparam int unsigned SHA256_MAX_BYTES  = 32'd52;
    // Message words presented to the core
    localparam int unsigned SHA256_WORD_COUNT = 32'd14;
    // Pad byte appended right after the last message byte
    localparam logic [7:0]  SHA256_PAD_BYTE   = 8'h80;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PRESENT = 2'd1,
        ST_DRAIN   = 2'd2
    } loader_state_t;

endpackage : sha256_pkg

// File: rtl/sha256_msg_loader.sv
// ----------------------------------------------------------------------------
// sha256_msg_loader
// Collects one AXI4-Stream byte packet, packs it big-endian into 14 words,
// appends the 0x80 pad byte, and presents the block to the SHA-256 core.
// Oversize packets are discarded and flagged with a msg_drop pulse.
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast     upstream message bytes
//   s_axis_tready                 loader can accept a byte (from state)
//   string_w0 .. string_w13       packed message words (registered)
//   string_size                   message length in bytes (registered)
//   string_dv                     block valid toward the core (registered)
//   string_ready                  core can capture a block
//   msg_drop                      one-cycle pulse: oversize message discarded
// ----------------------------------------------------------------------------
module sha256_msg_loader
    import sha256_pkg::*;
#(
    parameter int unsigned MAX_BYTES = SHA256_MAX_BYTES
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] string_w0,
    output logic [31:0] string_w1,
    output logic [31:0] string_w2,
    output logic [31:0] string_w3,
    output logic [31:0] string_w4,
    output logic [31:0] string_w5,
    output logic [31:0] string_w6,
    output logic [31:0] string_w7,
    output logic [31:0] string_w8,
    output logic [31:0] string_w9,
    output logic [31:0] string_w10,
    output logic [31:0] string_w11,
    output logic [31:0] string_w12,
    output logic [31:0] string_w13,
    output logic [7:0]  string_size,
    output logic        string_dv,
    input  logic        string_ready,
    output logic        msg_drop
);

    localparam logic [5:0] MAX_CNT = 6'(MAX_BYTES);

    loader_state_t state_r;
    loader_state_t state_next_s;

    logic [31:0] words_r [SHA256_WORD_COUNT];
    logic [5:0]  cnt_r;
    logic [5:0]  cnt_next_s;
    logic [7:0]  size_r;
    logic [7:0]  size_next_s;
    logic        dv_r;
    logic        dv_next_s;
    logic        drop_r;
    logic        drop_next_s;

    logic        byte_xfer_s;
    logic        wr_byte_s;
    logic        wr_pad_s;
    logic        clr_s;

    // Gating with aresetn keeps tready low for the whole reset window even
    // though the reset state itself is COLLECT.
    assign s_axis_tready = aresetn && (state_r != ST_PRESENT);
    assign byte_xfer_s   = s_axis_tvalid && s_axis_tready;

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= ST_COLLECT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and datapath control
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        size_next_s  = size_r;
        dv_next_s    = dv_r;
        drop_next_s  = 1'b0;
        wr_byte_s    = 1'b0;
        wr_pad_s     = 1'b0;
        clr_s        = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (byte_xfer_s) begin
                    if (cnt_r == MAX_CNT) begin
                        // One byte past the limit: discard the message
                        if (s_axis_tlast) begin
                            drop_next_s = 1'b1;
                            clr_s       = 1'b1;
                            cnt_next_s  = 6'd0;
                        end else begin
                            state_next_s = ST_DRAIN;
                        end
                    end else begin
                        wr_byte_s  = 1'b1;
                        cnt_next_s = cnt_r + 6'd1;
                        if (s_axis_tlast) begin
                            // Pad byte goes right after the last byte, same edge
                            wr_pad_s     = 1'b1;
                            size_next_s  = {2'b00, cnt_r} + 8'd1;
                            dv_next_s    = 1'b1;
                            state_next_s = ST_PRESENT;
                        end else begin
                            state_next_s = ST_COLLECT;
                        end
                    end
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_PRESENT: begin
                if (dv_r && string_ready) begin
                    // Block accepted: dv drops next cycle so it is captured once
                    clr_s        = 1'b1;
                    cnt_next_s   = 6'd0;
                    size_next_s  = 8'd0;
                    dv_next_s    = 1'b0;
                    state_next_s = ST_COLLECT;
                end else begin
                    state_next_s = ST_PRESENT;
                end
            end
            ST_DRAIN: begin
                if (byte_xfer_s && s_axis_tlast) begin
                    drop_next_s  = 1'b1;
                    clr_s        = 1'b1;
                    cnt_next_s   = 6'd0;
                    state_next_s = ST_COLLECT;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                clr_s        = 1'b1;
                cnt_next_s   = 6'd0;
                size_next_s  = 8'd0;
                dv_next_s    = 1'b0;
                state_next_s = ST_COLLECT;
            end
        endcase
    end

    // Byte count, size, dv and drop registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_r  <= 6'd0;
            size_r <= 8'd0;
            dv_r   <= 1'b0;
            drop_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            size_r <= size_next_s;
            dv_r   <= dv_next_s;
            drop_r <= drop_next_s;
        end
    end

    // Word buffer with per-byte-lane write enables; byte n lands in word n/4,
    // lane n%4 counted from the most significant byte.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int w = 0; w < SHA256_WORD_COUNT; w++) begin
                words_r[w] <= 32'd0;
            end
        end else if (clr_s) begin
            for (int w = 0; w < SHA256_WORD_COUNT; w++) begin
                words_r[w] <= 32'd0;
            end
        end else begin
            for (int w = 0; w < SHA256_WORD_COUNT; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_byte_s && (cnt_r == 6'(w * 4 + b))) begin
                        words_r[w][31 - 8 * b -: 8] <= s_axis_tdata;
                    end else if (wr_pad_s && ((cnt_r + 6'd1) == 6'(w * 4 + b))) begin
                        words_r[w][31 - 8 * b -: 8] <= SHA256_PAD_BYTE;
                    end
                end
            end
        end
    end

    assign string_w0   = words_r[0];
    assign string_w1   = words_r[1];
    assign string_w2   = words_r[2];
    assign string_w3   = words_r[3];
    assign string_w4   = words_r[4];
    assign string_w5   = words_r[5];
    assign string_w6   = words_r[6];
    assign string_w7   = words_r[7];
    assign string_w8   = words_r[8];
    assign string_w9   = words_r[9];
    assign string_w10  = words_r[10];
    assign string_w11  = words_r[11];
    assign string_w12  = words_r[12];
    assign string_w13  = words_r[13];
    assign string_size = size_r;
    assign string_dv   = dv_r;
    assign msg_drop    = drop_r;

endmodule : sha256_msg_loader

// File: tb/tb_sha256_msg_loader.sv
// ----------------------------------------------------------------------------
// tb_sha256_msg_loader
// Self-checking bench: every message driven pushes its expected outcome (a
// packed block or a drop) into a scoreboard queue; a negedge monitor pops and
// compares when the core accepts a block or msg_drop pulses.
// ----------------------------------------------------------------------------
module tb_sha256_msg_loader;

    localparam int MAX_B = 52;

    typedef struct packed {
        logic               drop;
        logic [13:0][31:0]  w;
        logic [7:0]         size;
    } exp_t;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] string_w0, string_w1, string_w2, string_w3, string_w4;
    logic [31:0] string_w5, string_w6, string_w7, string_w8, string_w9;
    logic [31:0] string_w10, string_w11, string_w12, string_w13;
    logic [7:0]  string_size;
    logic        string_dv;
    logic        string_ready;
    logic        msg_drop;

    logic [13:0][31:0] obs_w;
    assign obs_w = {string_w13, string_w12, string_w11, string_w10, string_w9,
                    string_w8, string_w7, string_w6, string_w5, string_w4,
                    string_w3, string_w2, string_w1, string_w0};

    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_count = 0;
    exp_t sb_q [$];
    logic [7:0] msg_buf [0:63];

    sha256_msg_loader #(.MAX_BYTES(MAX_B)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .string_w0     (string_w0),
        .string_w1     (string_w1),
        .string_w2     (string_w2),
        .string_w3     (string_w3),
        .string_w4     (string_w4),
        .string_w5     (string_w5),
        .string_w6     (string_w6),
        .string_w7     (string_w7),
        .string_w8     (string_w8),
        .string_w9     (string_w9),
        .string_w10    (string_w10),
        .string_w11    (string_w11),
        .string_w12    (string_w12),
        .string_w13    (string_w13),
        .string_size   (string_size),
        .string_dv     (string_dv),
        .string_ready  (string_ready),
        .msg_drop      (msg_drop)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive msg_buf[0..len-1]; entered and left at a negedge.
    task automatic send_msg(input int len, input bit do_last);
        exp_t e;
        int   n;
        if (do_last) begin
            e = '0;
            if (len <= MAX_B) begin
                for (int i = 0; i < len; i++) e.w[i / 4][31 - 8 * (i % 4) -: 8] = msg_buf[i];
                e.w[len / 4][31 - 8 * (len % 4) -: 8] = 8'h80;
                e.size = 8'(len);
            end else begin
                e.drop = 1'b1;
            end
            sb_q.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = msg_buf[i];
            s_axis_tlast  = do_last && (i == len - 1);
            n = 0;
            while (!s_axis_tready && n < 1000) begin
                @(negedge aclk);
                n++;
            end
            if (n >= 1000) check("tready_timeout", 32'd0, 32'd1);
            @(negedge aclk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'hxx;
    endtask

    task automatic load_abc();
        msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv"},    32'(string_dv),     32'd0);
        check({tag, "_tready"},32'(s_axis_tready), 32'd0);
        check({tag, "_drop"},  32'(msg_drop),      32'd0);
        check({tag, "_size"},  32'(string_size),   32'd0);
        check({tag, "_words"}, 32'(obs_w != '0),   32'd0);
    endtask

    // Scoreboard monitor: compare at the negedge before each accepting edge
    initial begin
        exp_t e;
        bit   prev_acc;
        prev_acc = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_acc = 1'b0;
            end else begin
                if (prev_acc) check("dv_low_after_accept", 32'(string_dv), 32'd0);
                prev_acc = 1'b0;
                if (msg_drop) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_drop", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("drop_expected", 32'(e.drop), 32'd1);
                    end
                end
                if (string_dv && string_ready) begin
                    acc_count++;
                    prev_acc = 1'b1;
                    if (sb_q.size() == 0) begin
                        check("unexpected_block", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("block_not_drop", 32'(e.drop), 32'd0);
                        for (int i = 0; i < 14; i++)
                            check($sformatf("blk_w%0d", i), obs_w[i], e.w[i]);
                        check("blk_size", 32'(string_size), 32'(e.size));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stable;
        int acc0;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = 8'h00;
        string_ready  = 1'b1;
        #12;
        check_reset_outputs("por");
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("tready_after_reset", 32'(s_axis_tready), 32'd1);

        // "abc" with the core ready
        load_abc();
        send_msg(3, 1'b1);
        check("abc_dv_rise", 32'(string_dv), 32'd1);
        check("abc_w0", string_w0, 32'h61626380);
        check("abc_size", 32'(string_size), 32'd3);
        check("abc_tready_low", 32'(s_axis_tready), 32'd0);
        @(negedge aclk);
        check("abc_dv_one_cycle", 32'(string_dv), 32'd0);
        check("abc_tready_back", 32'(s_axis_tready), 32'd1);

        // 52-byte message, the largest legal one
        for (int i = 0; i < 52; i++) msg_buf[i] = 8'(i);
        send_msg(52, 1'b1);
        check("m52_w12", string_w12, 32'h30313233);
        check("m52_w13", string_w13, 32'h80000000);
        check("m52_size", 32'(string_size), 32'd52);
        check("m52_drop", 32'(msg_drop), 32'd0);
        repeat (2) @(negedge aclk);

        // 53-byte message is dropped at its tlast
        for (int i = 0; i < 53; i++) msg_buf[i] = 8'(i);
        send_msg(53, 1'b1);
        check("m53_drop_pulse", 32'(msg_drop), 32'd1);
        check("m53_no_dv", 32'(string_dv), 32'd0);
        @(negedge aclk);
        check("m53_drop_end", 32'(msg_drop), 32'd0);
        msg_buf[0] = 8'h61;
        send_msg(1, 1'b1);
        check("a_w0", string_w0, 32'h61800000);
        repeat (2) @(negedge aclk);

        // 60-byte message goes through the drain path
        for (int i = 0; i < 60; i++) msg_buf[i] = 8'(8'hA0 + 8'(i));
        send_msg(60, 1'b1);
        check("m60_drop_pulse", 32'(msg_drop), 32'd1);
        check("m60_no_dv", 32'(string_dv), 32'd0);
        repeat (2) @(negedge aclk);

        // Back-pressure: core not ready for 100 cycles
        string_ready = 1'b0;
        load_abc();
        send_msg(3, 1'b1);
        stable = 0;
        for (int i = 0; i < 100; i++) begin
            if (string_dv && string_w0 == 32'h61626380 && !s_axis_tready) stable++;
            @(negedge aclk);
        end
        check("bp_stable_cycles", 32'(stable), 32'd100);
        check("bp_dv_held", 32'(string_dv), 32'd1);
        acc0 = acc_count;
        @(posedge aclk);
        #1 string_ready = 1'b1;
        repeat (3) @(negedge aclk);
        check("bp_one_accept", 32'(acc_count - acc0), 32'd1);
        check("bp_dv_low", 32'(string_dv), 32'd0);

        // Back-to-back messages; stale bytes must not survive
        msg_buf[0] = 8'h41; msg_buf[1] = 8'h42; msg_buf[2] = 8'h43; msg_buf[3] = 8'h44;
        msg_buf[4] = 8'h45; msg_buf[5] = 8'h46; msg_buf[6] = 8'h47; msg_buf[7] = 8'h48;
        send_msg(8, 1'b1);
        msg_buf[0] = 8'h61; msg_buf[1] = 8'h62;
        send_msg(2, 1'b1);
        check("b2b_w0", string_w0, 32'h61628000);
        check("b2b_w1", string_w1, 32'h00000000);
        check("b2b_size", 32'(string_size), 32'd2);
        repeat (2) @(negedge aclk);

        // Reset after 10 bytes of a message
        for (int i = 0; i < 10; i++) msg_buf[i] = 8'(8'h10 + 8'(i));
        send_msg(10, 1'b0);
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        load_abc();
        send_msg(3, 1'b1);
        check("rst_mid_abc_w0", string_w0, 32'h61626380);
        repeat (2) @(negedge aclk);

        // Reset while presenting a block
        string_ready = 1'b0;
        load_abc();
        send_msg(3, 1'b1);
        check("rst_pres_dv_before", 32'(string_dv), 32'd1);
        #2 aresetn = 1'b0;
        sb_q.delete();
        #1 check_reset_outputs("rst_pres");
        @(negedge aclk);
        aresetn = 1'b1;
        string_ready = 1'b1;
        @(negedge aclk);
        check("rst_pres_no_dv", 32'(string_dv), 32'd0);
        load_abc();
        send_msg(3, 1'b1);
        check("rst_pres_abc_w0", string_w0, 32'h61626380);
        check("rst_pres_abc_size", 32'(string_size), 32'd3);
        repeat (4) @(negedge aclk);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sha256_msg_loader
